// File: rtl/network_descriptor_dispatch.sv
// rtl/network_descriptor_dispatch.sv - per-destination descriptor queues with valid/ack handshakes
// Three independent FWFT queues (host, HCP, network) behind a single-request upstream port.

module ndd_queue #(
    parameter int AW = 2,
    parameter int W  = 57
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [W-1:0]  data_o,
    output logic [AW:0]   usedw_o
);
    localparam int N = 2**AW;

    logic [W-1:0]  mem_q [N];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   usedw_q;
    logic [AW:0]   usedw_d;
    logic          pop_ok;

    // A pop against an empty queue is dropped so usedw cannot underflow.
    assign pop_ok = pop_i && (usedw_q != '0);

    always_comb begin
        usedw_d = usedw_q;
        if (push_i && !pop_ok) begin
            usedw_d = usedw_q + 1'b1;
        end else if (!push_i && pop_ok) begin
            usedw_d = usedw_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
        end else begin
            usedw_q <= usedw_d;
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Head is masked while empty so a reset queue presents all-zero data.
    assign valid_o = (usedw_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign usedw_o = usedw_q;
endmodule

module network_descriptor_dispatch #(
    parameter int DEPTH_AW = 2
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                i_descriptor_wr_to_host,
    input  logic                i_descriptor_wr_to_hcp,
    input  logic                i_descriptor_wr_to_network,
    input  logic [56:0]         iv_descriptor,
    input  logic                i_inverse_map_lookup_flag,
    output logic                o_descriptor_ack,
    output logic                o_host_descriptor_wr,
    output logic [56:0]         ov_host_descriptor,
    input  logic                i_host_descriptor_ack,
    output logic                o_hcp_descriptor_wr,
    output logic [56:0]         ov_hcp_descriptor,
    input  logic                i_hcp_descriptor_ack,
    output logic                o_network_descriptor_wr,
    output logic [57:0]         ov_network_descriptor,
    input  logic                i_network_descriptor_ack,
    output logic [DEPTH_AW:0]   ov_host_usedw,
    output logic [DEPTH_AW:0]   ov_hcp_usedw,
    output logic [DEPTH_AW:0]   ov_network_usedw,
    output logic                o_descriptor_error_pulse
);
    localparam logic [DEPTH_AW:0] FULL = (DEPTH_AW+1)'(2**DEPTH_AW);

    logic [2:0] wr_vec;
    logic       multi;
    logic       acc_host, acc_hcp, acc_net;
    logic       ack_q, ack_d;
    logic       err_q, err_d;

    assign wr_vec = {i_descriptor_wr_to_network, i_descriptor_wr_to_hcp, i_descriptor_wr_to_host};
    assign multi  = (wr_vec & (wr_vec - 3'd1)) != 3'd0;

    // The visible ack doubles as the guard: upstream still holds wr during that cycle.
    always_comb begin
        acc_host = !ack_q && (wr_vec == 3'b001) && (ov_host_usedw != FULL);
        acc_hcp  = !ack_q && (wr_vec == 3'b010) && (ov_hcp_usedw != FULL);
        acc_net  = !ack_q && (wr_vec == 3'b100) && (ov_network_usedw != FULL);
        err_d    = !ack_q && multi;
        ack_d    = acc_host || acc_hcp || acc_net || err_d;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    assign o_descriptor_ack         = ack_q;
    assign o_descriptor_error_pulse = err_q;

    ndd_queue #(.AW(DEPTH_AW), .W(57)) u_host_q (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .push_i  (acc_host),
        .data_i  (iv_descriptor),
        .pop_i   (i_host_descriptor_ack),
        .valid_o (o_host_descriptor_wr),
        .data_o  (ov_host_descriptor),
        .usedw_o (ov_host_usedw)
    );

    ndd_queue #(.AW(DEPTH_AW), .W(57)) u_hcp_q (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .push_i  (acc_hcp),
        .data_i  (iv_descriptor),
        .pop_i   (i_hcp_descriptor_ack),
        .valid_o (o_hcp_descriptor_wr),
        .data_o  (ov_hcp_descriptor),
        .usedw_o (ov_hcp_usedw)
    );

    ndd_queue #(.AW(DEPTH_AW), .W(58)) u_net_q (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .push_i  (acc_net),
        .data_i  ({i_inverse_map_lookup_flag, iv_descriptor}),
        .pop_i   (i_network_descriptor_ack),
        .valid_o (o_network_descriptor_wr),
        .data_o  (ov_network_descriptor),
        .usedw_o (ov_network_usedw)
    );
endmodule
